// File: rtl/axis_latency_checker.sv
`default_nettype none
// ============================================================================
// Module      : axis_latency_checker
// Description : Terminal AXI-Stream sink. Checks TDEST, per-source sequence
//               numbers and payload integrity of each packet, and accumulates
//               per-source packet counts plus latency min/max/sum measured
//               against the shared free-running ticks counter.
//               Optional random backpressure (16-bit LFSR on tready) is built
//               when AXIS_LATENCY_CHECKER_BACKPRESSURE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_latency_checker #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int NUM_ROUTERS = 2,
    parameter int TDEST       = 0,
    parameter int COUNT_WIDTH = 32,
    parameter int SUM_WIDTH   = 48,
    parameter int MAX_FLITS   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [TDATA_WIDTH/2-1:0]               ticks,
    input  logic                                   axis_in_tvalid,
    output logic                                   axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]                 axis_in_tdata,
    input  logic                                   axis_in_tlast,
    input  logic [TDEST_WIDTH-1:0]                 axis_in_tdest,
    input  logic [TID_WIDTH-1:0]                   axis_in_tid,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_packets,
    output logic [COUNT_WIDTH-1:0]                 total_recv_packets,
    output logic [TDATA_WIDTH/2-1:0]               lat_min,
    output logic [TDATA_WIDTH/2-1:0]               lat_max,
    output logic [SUM_WIDTH-1:0]                   lat_sum,
    output logic                                   error,
    output logic [2:0]                             error_code,
    output logic                                   busy
);

    localparam int c_half_w = TDATA_WIDTH / 2;
    localparam int c_idx_w  = $clog2(MAX_FLITS + 1);

    localparam logic [c_idx_w-1:0]     c_max_flits   = c_idx_w'(MAX_FLITS);
    localparam logic [TID_WIDTH:0]     c_num_routers = (TID_WIDTH + 1)'(NUM_ROUTERS);
    localparam logic [TDEST_WIDTH-1:0] c_tdest       = TDEST_WIDTH'(TDEST);

    localparam logic [2:0] c_err_tdest   = 3'd1;
    localparam logic [2:0] c_err_seq     = 3'd2;
    localparam logic [2:0] c_err_payload = 3'd3;
    localparam logic [2:0] c_err_tid     = 3'd4;
    localparam logic [2:0] c_err_count   = 3'd5;
    localparam logic [2:0] c_err_src     = 3'd6;

    typedef enum logic [0:0] {
        S_HEAD = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_ready;
    logic                   w_acc;

    // Context of the packet in flight, captured from its head flit
    logic [TID_WIDTH-1:0]   r_tid;
    logic [c_half_w-1:0]    r_seq;
    logic [c_half_w-1:0]    r_ts;
    logic [c_idx_w-1:0]     r_flit_idx;
    logic                   r_tid_bad;

    logic [c_half_w-1:0]    r_expected [NUM_ROUTERS];
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] r_recv;
    logic [COUNT_WIDTH-1:0] r_total;
    logic [c_half_w-1:0]    r_lat_min;
    logic [c_half_w-1:0]    r_lat_max;
    logic [SUM_WIDTH-1:0]   r_lat_sum;
    logic                   r_error;
    logic [2:0]             r_error_code;

    logic [c_half_w-1:0]    w_in_seq;
    logic [c_half_w-1:0]    w_in_lo;
    logic                   w_tid_bad;
    logic [c_half_w-1:0]    w_exp_seq;
    logic [TDATA_WIDTH-1:0] w_body_exp;

    logic                   w_close;
    logic                   w_count;
    logic [2:0]             w_err_code;
    logic [TID_WIDTH-1:0]   w_close_tid;
    logic [c_half_w-1:0]    w_close_seq;
    logic [c_half_w-1:0]    w_close_ts;
    logic                   w_close_bad;
    logic [c_half_w-1:0]    w_latency;
    logic [SUM_WIDTH:0]     w_sum_ext;

    assign w_acc      = axis_in_tvalid & axis_in_tready;
    assign w_in_seq   = axis_in_tdata[TDATA_WIDTH-1:c_half_w];
    assign w_in_lo    = axis_in_tdata[c_half_w-1:0];
    assign w_tid_bad  = ({1'b0, axis_in_tid} >= c_num_routers);
    assign w_body_exp = {r_seq, {(c_half_w - c_idx_w){1'b0}}, r_flit_idx};

    // Ready is held low while in reset and rises on the first free cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

`ifdef AXIS_LATENCY_CHECKER_BACKPRESSURE_EN
    localparam logic [15:0] c_lfsr_seed = 16'hACE1 + 16'(TDEST);

    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR; two low bits give roughly 75% ready duty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign axis_in_tready = r_ready & (r_lfsr[1:0] != 2'b00);
`else
    assign axis_in_tready = r_ready;
`endif

    // Look up the next expected sequence number of the incoming source
    always_comb begin
        w_exp_seq = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (axis_in_tid == TID_WIDTH'(i)) begin
                w_exp_seq = r_expected[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_HEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, per-flit checks and packet-close decode
    always_comb begin
        w_state_nxt = r_state;
        w_close     = 1'b0;
        w_err_code  = 3'd0;
        w_close_tid = r_tid;
        w_close_seq = r_seq;
        w_close_ts  = r_ts;
        w_close_bad = r_tid_bad;
        case (r_state)
            S_HEAD: begin
                // A head-only packet closes with the head's own context
                w_close_tid = axis_in_tid;
                w_close_seq = w_in_seq;
                w_close_ts  = w_in_lo;
                w_close_bad = w_tid_bad;
                if (w_acc) begin
                    if (axis_in_tdest != c_tdest) begin
                        w_err_code = c_err_tdest;
                    end else if (w_tid_bad) begin
                        w_err_code = c_err_src;
                    end else if (w_in_seq != w_exp_seq) begin
                        w_err_code = c_err_seq;
                    end
                    if (axis_in_tlast) begin
                        w_close = 1'b1;
                    end else begin
                        w_state_nxt = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (w_acc) begin
                    if (axis_in_tdest != c_tdest) begin
                        w_err_code = c_err_tdest;
                    end else if (axis_in_tdata != w_body_exp) begin
                        w_err_code = c_err_payload;
                    end else if (axis_in_tid != r_tid) begin
                        w_err_code = c_err_tid;
                    end else if (r_flit_idx >= c_max_flits) begin
                        w_err_code = c_err_count;
                    end
                    // An over-long packet is closed as if tlast were set
                    if (axis_in_tlast || (r_flit_idx >= c_max_flits)) begin
                        w_close     = 1'b1;
                        w_state_nxt = S_HEAD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HEAD;
            end
        endcase
    end

    assign w_count   = w_close & ~w_close_bad;
    assign w_latency = ticks - w_close_ts;
    assign w_sum_ext = {1'b0, r_lat_sum} + {{(SUM_WIDTH + 1 - c_half_w){1'b0}}, w_latency};

    // Capture packet context on the head and track the body flit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tid      <= '0;
            r_seq      <= '0;
            r_ts       <= '0;
            r_flit_idx <= '0;
            r_tid_bad  <= 1'b0;
        end else if (w_acc) begin
            if (r_state == S_HEAD) begin
                r_tid      <= axis_in_tid;
                r_seq      <= w_in_seq;
                r_ts       <= w_in_lo;
                r_flit_idx <= c_idx_w'(1);
                r_tid_bad  <= w_tid_bad;
            end else if (!w_close) begin
                r_flit_idx <= r_flit_idx + 1'b1;
            end
        end
    end

    // Sticky error flag; only the first cause is kept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_error      <= 1'b0;
            r_error_code <= 3'd0;
        end else if (w_err_code != 3'd0) begin
            r_error <= 1'b1;
            if (!r_error) begin
                r_error_code <= w_err_code;
            end
        end
    end

    // Per-source counters and expected sequence numbers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                r_recv[i]     <= '0;
                r_expected[i] <= '0;
            end
        end else if (w_count) begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                if (w_close_tid == TID_WIDTH'(i)) begin
                    r_expected[i] <= w_close_seq + 1'b1;
                    if (r_recv[i] != '1) begin
                        r_recv[i] <= r_recv[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Aggregate packet count and latency statistics, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_total   <= '0;
            r_lat_min <= '1;
            r_lat_max <= '0;
            r_lat_sum <= '0;
        end else if (w_count) begin
            if (r_total != '1) begin
                r_total <= r_total + 1'b1;
            end
            if (w_latency < r_lat_min) begin
                r_lat_min <= w_latency;
            end
            if (w_latency > r_lat_max) begin
                r_lat_max <= w_latency;
            end
            if (w_sum_ext[SUM_WIDTH]) begin
                r_lat_sum <= '1;
            end else begin
                r_lat_sum <= w_sum_ext[SUM_WIDTH-1:0];
            end
        end
    end

    assign recv_packets       = r_recv;
    assign total_recv_packets = r_total;
    assign lat_min            = r_lat_min;
    assign lat_max            = r_lat_max;
    assign lat_sum            = r_lat_sum;
    assign error              = r_error;
    assign error_code         = r_error_code;
    assign busy               = (r_state == S_BODY);

endmodule
`default_nettype wire

// File: doc/axis_latency_checker.md
Name: axis_latency_checker

Overview:
- Terminal AXI-Stream sink at each endpoint, directly downstream of axis_deserializer_shim_out.
- Consumes packets delivered by the NoC and checks TDEST, per-source sequence number and payload integrity.
- Accumulates per-source packet counts and packet latency statistics (min/max/sum) against the shared free-running ticks counter.
- Used by the load-sweep harnesses to produce latency-vs-load curves.

Parameters:
- TDATA_WIDTH, 64, flit data width; must be even and >= 16.
- TDEST_WIDTH, 1, width of TDEST (destination endpoint index).
- TID_WIDTH, 1, width of TID (source endpoint index).
- NUM_ROUTERS, 2, number of sources tracked (<= 2**TID_WIDTH).
- TDEST, 0, this endpoint's index; every accepted flit must carry it.
- COUNT_WIDTH, 32, width of packet counters.
- SUM_WIDTH, 48, width of latency accumulator.
- MAX_FLITS, 16, maximum legal flits per packet.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ticks  in  TDATA_WIDTH/2  shared free-running cycle counter
- axis_in_tvalid  in  1  flit valid
- axis_in_tready  out  1  flit ready
- axis_in_tdata  in  TDATA_WIDTH  flit payload
- axis_in_tlast  in  1  tail flit
- axis_in_tdest  in  TDEST_WIDTH  destination
- axis_in_tid  in  TID_WIDTH  source
- recv_packets  out  [NUM_ROUTERS] x COUNT_WIDTH  packets received per source
- total_recv_packets  out  COUNT_WIDTH  sum over all sources
- lat_min  out  TDATA_WIDTH/2  minimum packet latency
- lat_max  out  TDATA_WIDTH/2  maximum packet latency
- lat_sum  out  SUM_WIDTH  latency accumulator
- error  out  1  sticky error flag
- error_code  out  3  first error cause
- busy  out  1  high while mid-packet

Behaviour:
- Reset:
  - All counters, lat_max, lat_sum, error and busy = 0.
  - lat_min = all-ones.
  - error_code = 0; expected sequence per source = 0.
  - axis_in_tready = 0 during reset, 1 in the first cycle after reset deasserts.
- Handshake: a flit is accepted when tvalid && tready. Without the optional feature, tready stays 1 after reset.
- Packet format:
  - Head tdata = {seq[H-1:0], timestamp[H-1:0]}, where H = TDATA_WIDTH/2.
  - Body flit k (k = 1..) tdata = {seq, k} with k zero-extended to H bits.
- FSM, two states:
  - HEAD:
    - On head acceptance, capture tid, seq and timestamp; set flit_idx = 1.
    - If tlast, close the packet in the same cycle.
    - Otherwise go to BODY; busy = 1.
  - BODY:
    - Check each flit against the captured seq and flit_idx, then increment flit_idx.
    - On tlast, close the packet and return to HEAD; busy = 0.
- Checks. The first failing check latches error_code; later errors only keep error = 1:
  - 1 = tdest != TDEST.
  - 2 = head seq != expected[tid].
  - 3 = body payload mismatch.
  - 4 = tid changed mid-packet.
  - 5 = flit count exceeded MAX_FLITS, with tlast forced into the count check.
  - 6 = tid >= NUM_ROUTERS. In this case the packet is not counted.
- Packet close:
  - latency = ticks - timestamp, modulo 2**H, so ticks wrap-around is handled.
  - The statistics update is registered and becomes visible one cycle after tail acceptance.
  - On close: recv_packets[tid]++, total_recv_packets++, expected[tid] = seq + 1, lat_sum += latency, lat_min = min, lat_max = max.
- Saturation:
  - Counters saturate at all-ones and do not wrap.
  - lat_sum saturates at all-ones.
- Head-only packet (tvalid && tlast in HEAD) counts as a full packet with zero body checks.
- A new head may be accepted in the cycle immediately after a tail, with no bubble.
- Reset mid-packet: the FSM returns to HEAD, all statistics clear, and the partial packet is discarded.
- Errors never stall the stream; acceptance continues.

Optional Feature:
- Macro: AXIS_LATENCY_CHECKER_BACKPRESSURE_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 + TDEST, advancing every cycle) drives tready = lfsr[1:0] != 0, giving about 75% ready.
  - Used to exercise NoC credit backpressure.
  - tready may fall without a handshake; this is legal AXIS.
- When undefined: tready = 1 after reset, and no LFSR logic is present.

Test Plan:
- Single head-only packet, tid=1, seq=0, timestamp=100, accepted at ticks=130 -> next cycle recv_packets[1]=1, total=1, lat_min=lat_max=lat_sum=30, error=0.
- 4-flit packet, tid=0, seq=0, body tdata {0,1},{0,2},{0,3}, then a second packet seq=1 back-to-back with no gap -> total=2, expected[0]=2, busy low after each tail, no error.
- Head with seq=5 when expected is 0 -> error=1, error_code=2; a subsequent tdest-mismatched flit keeps error_code=2.
- timestamp=32'hFFFF_FFF0 accepted at ticks=32'h10 -> latency=32; lat_max=32.
- 17-flit packet with MAX_FLITS=16 -> error_code=5. Then assert rst_n=0 for 1 cycle mid-next-packet -> all stats cleared, lat_min=all-ones, a fresh packet with seq=0 is accepted cleanly.
- With AXIS_LATENCY_CHECKER_BACKPRESSURE_EN, 1000 random packets -> tready duty 70–80%, all packets counted, error=0.
